// File: rtl/kernel_run_ctrl.sv
// ap_ctrl_hs run controller for NUM_CORES pipelined RISC-V kernels: reset sequencing, PC-based halt detection, drain, done.
// Optional run-cycle watchdog is compiled in when KERNEL_TIMEOUT_EN is defined.
module kernel_run_ctrl #(
    parameter int unsigned NUM_CORES      = 1,
    parameter int unsigned PC_WIDTH       = 32,
    parameter int unsigned HALT_WORD_ADDR = 40,
    parameter int unsigned RST_CYCLES     = 2,
    parameter int unsigned DRAIN_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic                          ap_start,
    output logic                          ap_done,
    output logic                          ap_ready,
    output logic                          ap_idle,
    input  logic [NUM_CORES*PC_WIDTH-1:0] core_pc,
    output logic [NUM_CORES-1:0]          core_rst_n,
    output logic [NUM_CORES-1:0]          core_run_en,
    output logic [31:0]                   cycle_count,
    output logic                          ap_timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [PC_WIDTH-3:0] LP_HALT_WORD  = (PC_WIDTH-2)'(HALT_WORD_ADDR);
    localparam logic [31:0]         LP_RST_LAST   = 32'(RST_CYCLES);
    localparam logic [31:0]         LP_DRAIN_LAST = 32'(DRAIN_CYCLES);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_ap_done;
    logic                  w_ap_done_next;
    logic                  r_ap_idle;
    logic                  w_ap_idle_next;
    logic                  r_ap_timeout;
    logic                  w_ap_timeout_next;
    logic [NUM_CORES-1:0]  r_core_rst_n;
    logic [NUM_CORES-1:0]  w_core_rst_n_next;
    logic [NUM_CORES-1:0]  r_core_run_en;
    logic [NUM_CORES-1:0]  w_core_run_en_next;
    logic [NUM_CORES-1:0]  r_halted;
    logic [NUM_CORES-1:0]  w_halted_next;
    logic [31:0]           r_cycle_count;
    logic [31:0]           w_cycle_count_next;
    logic [31:0]           r_phase_cnt;
    logic [31:0]           w_phase_cnt_next;

    logic [NUM_CORES-1:0]  w_halt_hit;
    logic [NUM_CORES-1:0]  w_pc_lsb;
    logic                  w_all_halted;
    logic [31:0]           w_count_inc;
    logic                  w_timeout_hit;
    logic                  w_unused;

    // Only running cores are compared, so a halted (stalled) core is never re-examined.
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        assign w_halt_hit[gi] = (r_state == S_RUN) && r_core_run_en[gi] &&
                                (core_pc[gi*PC_WIDTH+2 +: PC_WIDTH-2] == LP_HALT_WORD);
        assign w_pc_lsb[gi]   = ^core_pc[gi*PC_WIDTH +: 2];
    end

    assign w_all_halted = &(r_halted | w_halt_hit);
    assign w_count_inc  = (r_cycle_count == 32'hFFFF_FFFF) ? r_cycle_count : r_cycle_count + 32'd1;

`ifdef KERNEL_TIMEOUT_EN
    localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT_CYCLES);

    // Fires on the edge where the count reaches the limit, so ap_done sees exactly TIMEOUT_CYCLES.
    assign w_timeout_hit = ((r_state == S_RUN) || (r_state == S_DRAIN)) && (w_count_inc == LP_TIMEOUT);
    assign w_unused      = ^w_pc_lsb;
`else
    assign w_timeout_hit = 1'b0;
    assign w_unused      = (^w_pc_lsb) ^ (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        w_state_next       = r_state;
        w_ap_done_next     = 1'b0;
        w_ap_idle_next     = r_ap_idle;
        w_ap_timeout_next  = r_ap_timeout;
        w_core_rst_n_next  = r_core_rst_n;
        w_core_run_en_next = r_core_run_en;
        w_halted_next      = r_halted;
        w_cycle_count_next = r_cycle_count;
        w_phase_cnt_next   = r_phase_cnt;

        case (r_state)
            S_IDLE: begin
                if (ap_start) begin
                    w_state_next       = S_CLR;
                    w_ap_idle_next     = 1'b0;
                    w_ap_timeout_next  = 1'b0;
                    w_halted_next      = '0;
                    w_cycle_count_next = 32'd0;
                    w_phase_cnt_next   = 32'd0;
                    w_core_rst_n_next  = '0;
                    w_core_run_en_next = '0;
                end
            end
            S_CLR: begin
                if (r_phase_cnt == LP_RST_LAST) begin
                    w_state_next       = S_RUN;
                    w_core_rst_n_next  = '1;
                    w_core_run_en_next = '1;
                end else begin
                    w_phase_cnt_next = r_phase_cnt + 32'd1;
                end
            end
            S_RUN: begin
                w_cycle_count_next = w_count_inc;
                w_halted_next      = r_halted | w_halt_hit;
                w_core_run_en_next = r_core_run_en & ~w_halt_hit;
                if (w_all_halted) begin
                    if (DRAIN_CYCLES == 0) begin
                        w_state_next   = S_DONE;
                        w_ap_done_next = 1'b1;
                    end else begin
                        // Cores re-enabled so in-flight writebacks retire; fetch sits at the halt PC.
                        w_state_next       = S_DRAIN;
                        w_phase_cnt_next   = 32'd0;
                        w_core_run_en_next = '1;
                    end
                end
            end
            S_DRAIN: begin
                w_cycle_count_next = w_count_inc;
                if (r_phase_cnt == LP_DRAIN_LAST) begin
                    w_state_next   = S_DONE;
                    w_ap_done_next = 1'b1;
                end else begin
                    w_phase_cnt_next = r_phase_cnt + 32'd1;
                end
            end
            S_DONE: begin
                w_state_next       = S_IDLE;
                w_ap_idle_next     = 1'b1;
                w_core_rst_n_next  = '0;
                w_core_run_en_next = '0;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_timeout_hit) begin
            w_state_next       = S_DONE;
            w_ap_done_next     = 1'b1;
            w_ap_timeout_next  = 1'b1;
            w_core_run_en_next = '0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state       <= S_IDLE;
            r_ap_done     <= 1'b0;
            r_ap_idle     <= 1'b1;
            r_ap_timeout  <= 1'b0;
            r_core_rst_n  <= '0;
            r_core_run_en <= '0;
            r_halted      <= '0;
            r_cycle_count <= 32'd0;
            r_phase_cnt   <= 32'd0;
        end else begin
            r_state       <= w_state_next;
            r_ap_done     <= w_ap_done_next;
            r_ap_idle     <= w_ap_idle_next;
            r_ap_timeout  <= w_ap_timeout_next;
            r_core_rst_n  <= w_core_rst_n_next;
            r_core_run_en <= w_core_run_en_next;
            r_halted      <= w_halted_next;
            r_cycle_count <= w_cycle_count_next;
            r_phase_cnt   <= w_phase_cnt_next;
        end
    end

    assign ap_done     = r_ap_done;
    assign ap_ready    = r_ap_done;
    assign ap_idle     = r_ap_idle;
    assign ap_timeout  = r_ap_timeout;
    assign core_rst_n  = r_core_rst_n;
    assign core_run_en = r_core_run_en;
    assign cycle_count = r_cycle_count;

endmodule
